// File: rtl/longop_issue_seq.sv
// Long-latency MDU/FPU issue sequencer: accepts one M-ext or FP op, stalls the
// pipeline for its class latency, then holds the result until writeback is granted.
module longop_issue_seq #(
    parameter int MUL_LAT  = 3,
    parameter int DIV_LAT  = 34,
    parameter int FADD_LAT = 4,
    parameter int FMUL_LAT = 5,
    parameter int FDIV_LAT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_flush,
    input  logic        i_id_valid,
    input  logic        i_id_is_mext,
    input  logic [2:0]  i_id_mext_funct3,
    input  logic        i_id_is_fop,
    input  logic [1:0]  i_id_fop_sel,
    input  logic [4:0]  i_id_rd,
    input  logic [31:0] i_unit_result,
    input  logic        i_wb_grant,
    output logic        o_stall,
    output logic        o_mdu_start,
    output logic        o_fpu_start,
    output logic [2:0]  o_mdu_op,
    output logic [1:0]  o_fpu_op,
    output logic        o_unit_kill,
    output logic        o_wb_valid,
    output logic        o_wb_float,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic [31:0] o_busy_cycles
);

    localparam int MAX_A   = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int MAX_B   = (FADD_LAT > FMUL_LAT) ? FADD_LAT : FMUL_LAT;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_LAT = (MAX_C > FDIV_LAT) ? MAX_C : FDIV_LAT;
    localparam int CW      = $clog2(MAX_LAT) + 1;

    localparam logic [CW-1:0] L_MUL  = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] L_DIV  = CW'(DIV_LAT - 1);
    localparam logic [CW-1:0] L_FADD = CW'(FADD_LAT - 1);
    localparam logic [CW-1:0] L_FMUL = CW'(FMUL_LAT - 1);
    localparam logic [CW-1:0] L_FDIV = CW'(FDIV_LAT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_bubble;
    logic          r_mdu_start;
    logic          r_fpu_start;
    logic [2:0]    r_mdu_op;
    logic [1:0]    r_fpu_op;
    logic          r_kill;
    logic          r_wb_valid;
    logic          r_wb_float;
    logic [4:0]    r_wb_rd;
    logic [31:0]   r_wb_data;
    logic [31:0]   r_busy_cycles;

    logic          w_accept;
    logic          w_stall;
    logic [CW-1:0] w_lat_m1;

    // The instruction still sitting in ID/EX right after writeback is the one
    // just completed, so accept is held off for that single bubble cycle.
    assign w_accept = (r_state == S_IDLE) & ~r_bubble & i_id_valid &
                      (i_id_is_mext | i_id_is_fop) & ~i_flush;
    assign w_stall  = w_accept | (r_state != S_IDLE);

    // Per-class latency reload value; M-extension takes priority over FP.
    always_comb begin
        w_lat_m1 = L_MUL;
        if (i_id_is_mext) begin
            w_lat_m1 = i_id_mext_funct3[2] ? L_DIV : L_MUL;
        end else begin
            case (i_id_fop_sel)
                2'b00, 2'b01: w_lat_m1 = L_FADD;
                2'b10:        w_lat_m1 = L_FMUL;
                2'b11:        w_lat_m1 = L_FDIV;
                default:      w_lat_m1 = L_FADD;
            endcase
        end
    end

    // Sequencer FSM with latency counter and writeback holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bubble    <= 1'b0;
            r_mdu_start <= 1'b0;
            r_fpu_start <= 1'b0;
            r_mdu_op    <= 3'd0;
            r_fpu_op    <= 2'd0;
            r_kill      <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_float  <= 1'b0;
            r_wb_rd     <= 5'd0;
            r_wb_data   <= 32'd0;
        end else begin
            r_mdu_start <= 1'b0;
            r_fpu_start <= 1'b0;
            r_kill      <= 1'b0;
            r_bubble    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state    <= S_BUSY;
                        r_cnt      <= w_lat_m1;
                        r_wb_rd    <= i_id_rd;
                        r_wb_float <= ~i_id_is_mext;
                        if (i_id_is_mext) begin
                            r_mdu_start <= 1'b1;
                            r_mdu_op    <= i_id_mext_funct3;
                        end else begin
                            r_fpu_start <= 1'b1;
                            r_fpu_op    <= i_id_fop_sel;
                        end
                    end
                end
                S_BUSY: begin
                    if (i_flush) begin
                        r_state <= S_IDLE;
                        r_kill  <= 1'b1;
                    end else if (r_cnt == '0) begin
                        r_wb_data  <= i_unit_result;
                        r_wb_valid <= 1'b1;
                        r_state    <= S_WB;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_WB: begin
                    if (i_wb_grant) begin
                        r_wb_valid <= 1'b0;
                        r_bubble   <= 1'b1;
                        r_state    <= S_IDLE;
                    end else if (i_flush) begin
                        r_wb_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_wb_valid <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy_cycles <= 32'd0;
        end else if (w_stall && (r_busy_cycles != 32'hFFFF_FFFF)) begin
            r_busy_cycles <= r_busy_cycles + 32'd1;
        end
    end

    assign o_stall       = w_stall;
    assign o_mdu_start   = r_mdu_start;
    assign o_fpu_start   = r_fpu_start;
    assign o_mdu_op      = r_mdu_op;
    assign o_fpu_op      = r_fpu_op;
    assign o_unit_kill   = r_kill;
    assign o_wb_valid    = r_wb_valid;
    assign o_wb_float    = r_wb_float;
    assign o_wb_rd       = r_wb_rd;
    assign o_wb_data     = r_wb_data;
    assign o_busy_cycles = r_busy_cycles;

endmodule

// File: tb/tb_longop_issue_seq.sv
// Bench for longop_issue_seq: directed scenarios plus random traffic, checked every
// cycle against a timeline model driven by cycle offsets from the accept cycle.
module tb_longop_issue_seq;

    localparam int MUL_LAT  = 3;
    localparam int DIV_LAT  = 34;
    localparam int FADD_LAT = 4;
    localparam int FMUL_LAT = 5;
    localparam int FDIV_LAT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_flush, i_id_valid, i_id_is_mext, i_id_is_fop, i_wb_grant;
    logic [2:0]  i_id_mext_funct3;
    logic [1:0]  i_id_fop_sel;
    logic [4:0]  i_id_rd;
    logic [31:0] i_unit_result;
    logic        o_stall, o_mdu_start, o_fpu_start, o_unit_kill, o_wb_valid, o_wb_float;
    logic [2:0]  o_mdu_op;
    logic [1:0]  o_fpu_op;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data, o_busy_cycles;

    longop_issue_seq #(
        .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .FADD_LAT(FADD_LAT),
        .FMUL_LAT(FMUL_LAT), .FDIV_LAT(FDIV_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_id_valid(i_id_valid),
        .i_id_is_mext(i_id_is_mext), .i_id_mext_funct3(i_id_mext_funct3),
        .i_id_is_fop(i_id_is_fop), .i_id_fop_sel(i_id_fop_sel), .i_id_rd(i_id_rd),
        .i_unit_result(i_unit_result), .i_wb_grant(i_wb_grant),
        .o_stall(o_stall), .o_mdu_start(o_mdu_start), .o_fpu_start(o_fpu_start),
        .o_mdu_op(o_mdu_op), .o_fpu_op(o_fpu_op), .o_unit_kill(o_unit_kill),
        .o_wb_valid(o_wb_valid), .o_wb_float(o_wb_float), .o_wb_rd(o_wb_rd),
        .o_wb_data(o_wb_data), .o_busy_cycles(o_busy_cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one op in flight, described by its accept cycle and latency.
    bit          m_act, m_blk, m_kill, m_mext;
    int          m_acc, m_lat, cyc;
    logic [2:0]  m_mop;
    logic [1:0]  m_fop;
    logic [4:0]  m_rd;
    logic [31:0] m_data, m_busy;

    function automatic int lat_of(input bit mext, input logic [2:0] f3, input logic [1:0] sel);
        if (mext) return f3[2] ? DIV_LAT : MUL_LAT;
        case (sel)
            2'b10:   return FMUL_LAT;
            2'b11:   return FDIV_LAT;
            default: return FADD_LAT;
        endcase
    endfunction

    task automatic model_check();
        int d;
        bit acc_e, stall_e, wbv_e, nblk, nkill;
        if (!rst_n) begin
            m_act = 0; m_blk = 0; m_kill = 0; m_busy = 32'd0; m_mop = 3'd0; m_fop = 2'd0;
            chk("rst_stall", {31'd0, o_stall}, 32'd0);
            chk("rst_mstart", {31'd0, o_mdu_start}, 32'd0);
            chk("rst_fstart", {31'd0, o_fpu_start}, 32'd0);
            chk("rst_kill", {31'd0, o_unit_kill}, 32'd0);
            chk("rst_wbv", {31'd0, o_wb_valid}, 32'd0);
            chk("rst_wbdata", o_wb_data, 32'd0);
            chk("rst_busy", o_busy_cycles, 32'd0);
            cyc++;
            return;
        end
        d       = cyc - m_acc;
        acc_e   = !m_act && !m_blk && i_id_valid && (i_id_is_mext || i_id_is_fop) && !i_flush;
        stall_e = acc_e || m_act;
        wbv_e   = m_act && (d > m_lat);
        chk("stall", {31'd0, o_stall}, {31'd0, stall_e});
        chk("mdu_start", {31'd0, o_mdu_start}, {31'd0, m_act && d == 1 && m_mext});
        chk("fpu_start", {31'd0, o_fpu_start}, {31'd0, m_act && d == 1 && !m_mext});
        chk("mdu_op", {29'd0, o_mdu_op}, {29'd0, m_mop});
        chk("fpu_op", {30'd0, o_fpu_op}, {30'd0, m_fop});
        chk("unit_kill", {31'd0, o_unit_kill}, {31'd0, m_kill});
        chk("wb_valid", {31'd0, o_wb_valid}, {31'd0, wbv_e});
        chk("busy_cycles", o_busy_cycles, m_busy);
        if (wbv_e) begin
            chk("wb_rd", {27'd0, o_wb_rd}, {27'd0, m_rd});
            chk("wb_float", {31'd0, o_wb_float}, {31'd0, !m_mext});
            chk("wb_data", o_wb_data, m_data);
        end
        nblk = 0; nkill = 0;
        if (!m_act) begin
            if (acc_e) begin
                m_act = 1; m_acc = cyc; m_mext = i_id_is_mext; m_rd = i_id_rd;
                m_lat = lat_of(i_id_is_mext, i_id_mext_funct3, i_id_fop_sel);
                if (i_id_is_mext) m_mop = i_id_mext_funct3;
                else m_fop = i_id_fop_sel;
            end
        end else if (d <= m_lat) begin
            if (i_flush) begin
                m_act = 0; nkill = 1;
            end else if (d == m_lat) begin
                m_data = i_unit_result;
            end
        end else begin
            if (i_wb_grant) begin
                m_act = 0; nblk = 1;
            end else if (i_flush) begin
                m_act = 0;
            end
        end
        if (stall_e && m_busy != 32'hFFFF_FFFF) m_busy = m_busy + 32'd1;
        m_blk = nblk; m_kill = nkill;
        cyc++;
    endtask

    bit last_stall, last_wbv, rand_mode;
    int st_len, kill_n, wbv_n, mst_cyc, fst_cyc;

    task automatic set_idle();
        i_id_valid = 0; i_id_is_mext = 0; i_id_is_fop = 0;
    endtask

    task automatic issue(input bit mext, input logic [2:0] f3, input logic [1:0] sel, input logic [4:0] rd);
        i_id_valid = 1; i_id_is_mext = mext; i_id_is_fop = !mext;
        i_id_mext_funct3 = f3; i_id_fop_sel = sel; i_id_rd = rd;
    endtask

    task automatic drive_random();
        int r;
        i_unit_result = $urandom;
        i_wb_grant    = $urandom_range(0, 1) == 1;
        i_flush       = $urandom_range(0, 39) == 0;
        if (!last_stall) begin
            r = $urandom_range(0, 9);
            i_id_valid = r < 8;
            i_id_is_mext = (r <= 2) || (r == 6);
            i_id_is_fop = (r >= 3 && r <= 6);
            i_id_mext_funct3 = 3'($urandom_range(0, 7));
            i_id_fop_sel = 2'($urandom_range(0, 3));
            i_id_rd = 5'($urandom_range(0, 31));
        end
    endtask

    task automatic step();
        int c;
        @(negedge clk);
        c = cyc;
        last_stall = o_stall;
        last_wbv = o_wb_valid;
        if (o_stall) st_len++;
        if (o_unit_kill) kill_n++;
        if (o_wb_valid) wbv_n++;
        if (o_mdu_start) mst_cyc = c;
        if (o_fpu_start) fst_cyc = c;
        model_check();
        @(posedge clk);
        #1;
        if (rand_mode) drive_random();
    endtask

    task automatic run_op(input string tag);
        step();
        for (int i = 0; i < 200 && last_stall; i++) step();
        chk({tag, "_drained"}, {31'd0, last_stall}, 32'd0);
    endtask

    initial begin
        rst_n = 0; rand_mode = 0; cyc = 0; m_acc = 0;
        i_flush = 0; i_wb_grant = 1; i_unit_result = 32'd0;
        i_id_mext_funct3 = 3'd0; i_id_fop_sel = 2'd0; i_id_rd = 5'd0;
        set_idle();
        step(); step();
        rst_n = 1;
        step();

        // FDIV first so busy_cycles equals its stall length
        i_unit_result = 32'hCAFE_0003;
        issue(0, 3'd0, 2'b11, 5'd3);
        st_len = 0;
        run_op("fdiv");
        set_idle();
        chk("fdiv_stall_len", st_len, FDIV_LAT + 2);
        chk("fdiv_busy", o_busy_cycles, 32'd18);

        i_unit_result = 32'h12;
        issue(1, 3'b000, 2'b00, 5'd5);
        st_len = 0;
        run_op("mul");
        set_idle();
        chk("mul_stall_len", st_len, MUL_LAT + 2);

        // DIV with grant withheld for the first three writeback cycles
        i_wb_grant = 0; i_unit_result = 32'hD1D1_0042;
        issue(1, 3'b100, 2'b00, 5'd17);
        st_len = 0; wbv_n = 0;
        step();
        for (int i = 0; i < 200 && last_stall; i++) begin
            step();
            if (wbv_n == 3) i_wb_grant = 1;
        end
        set_idle();
        chk("div_wb_hold", wbv_n, 4);
        chk("div_stall_len", st_len, DIV_LAT + 5);

        // flush in the second BUSY cycle of a DIV
        issue(1, 3'b101, 2'b00, 5'd9);
        kill_n = 0; wbv_n = 0; st_len = 0;
        step(); step();
        i_flush = 1;
        step();
        i_flush = 0;
        set_idle();
        for (int i = 0; i < 6; i++) step();
        chk("flush_kill_n", kill_n, 1);
        chk("flush_wbv_n", wbv_n, 0);
        chk("flush_stall_len", st_len, 3);

        // flush together with a valid op in IDLE
        issue(1, 3'b001, 2'b00, 5'd2);
        i_flush = 1; st_len = 0; mst_cyc = -1;
        step(); step();
        i_flush = 0;
        set_idle();
        step();
        chk("idle_flush_stall", st_len, 0);
        chk("idle_flush_start", mst_cyc, -1);

        // back-to-back MUL then FADD
        mst_cyc = -1; fst_cyc = -1;
        issue(1, 3'b011, 2'b00, 5'd7);
        run_op("b2b_mul");
        issue(0, 3'd0, 2'b00, 5'd8);
        run_op("b2b_fadd");
        set_idle();
        chk("b2b_gap", fst_cyc - mst_cyc, MUL_LAT + 3);

        // reset in the middle of a DIV, then a clean MUL
        issue(1, 3'b110, 2'b00, 5'd30);
        for (int i = 0; i < 5; i++) step();
        rst_n = 0;
        set_idle();
        #1;
        chk("midrst_stall", {31'd0, o_stall}, 32'd0);
        chk("midrst_busy", o_busy_cycles, 32'd0);
        chk("midrst_kill", {31'd0, o_unit_kill}, 32'd0);
        step(); step();
        rst_n = 1;
        step();
        i_unit_result = 32'h0BAD_F00D;
        issue(1, 3'b010, 2'b00, 5'd12);
        st_len = 0;
        run_op("recov");
        set_idle();
        chk("recov_stall_len", st_len, MUL_LAT + 2);

        rand_mode = 1;
        last_stall = 0;
        drive_random();
        for (int i = 0; i < 3000; i++) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
